prpg_seq_engine: RTL and testbench

Parametrised successor to the 8-bit PRPG instruction processor, fully clocked.
- Fetches instructions from an external synchronous program ROM.
- Drives a W-bit programmable LFSR in Galois or Fibonacci mode and runs it for multi-cycle step counts.
- Stores and loads patterns in an internal DEPTH-entry pattern memory.
- Sits between the test-program ROM and the scan-pattern consumer; software starts it and observes busy/done/err.

---
 rtl/prpg_pkg.sv | 32 +++
 rtl/prpg_lfsr_step.sv | 41 ++++
 rtl/prpg_seq_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_prpg_seq_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prpg_pkg.sv
// Shared definitions for the PRPG sequence engine: opcodes, FSM states and
// LFSR mode encodings. Optional feature macro: PRPG_MISR_EN (enables OP_MISR).
package prpg_pkg;

   localparam int OP_W = 4;

   // LFSR mode encodings
   localparam logic GALOIS    = 1'b0;
   localparam logic FIBONACCI = 1'b1;

   typedef enum logic [OP_W-1:0] {
      OP_HALT  = 4'd0,
      OP_CFG   = 4'd1,
      OP_SEED  = 4'd2,
      OP_RUN   = 4'd3,
      OP_IADDR = 4'd4,
      OP_ST    = 4'd5,
      OP_LD    = 4'd6,
      OP_AADD  = 4'd7,
      OP_MODE  = 4'd8,
      OP_MISR  = 4'd9
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/prpg_lfsr_step.sv
// One-step next-state function for the programmable LFSR.
// Galois: bit W-1 is the feedback bit, XORed into every tapped position.
// Fibonacci: shift left, new bit 0 is the parity of the tapped state bits.
// Optional feature macro: PRPG_MISR_EN (adds sig_in, XORed into the result).
module prpg_lfsr_step
   import prpg_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] q,
   input  logic [W-1:0] tap,
   input  logic         mode,
`ifdef PRPG_MISR_EN
   input  logic [W-1:0] sig_in,
`endif
   output logic [W-1:0] q_next
);

   logic         w_fb;
   logic [W-1:0] w_galois;
   logic [W-1:0] w_fibonacci;
   logic [W-1:0] w_step;

   assign w_fb = q[W-1];

   // tap[0] never matters: bit 0 always receives the feedback bit itself.
   assign w_galois    = {q[W-2:0], w_fb} ^ ({tap[W-1:1], 1'b0} & {W{w_fb}});
   assign w_fibonacci = {q[W-2:0], ^(q & tap)};

   // Select the step flavour and fold in the signature input when present
   always_comb begin
      // NOTE: every combinational output gets a value on all paths, else a latch is inferred.
      w_step = (mode == FIBONACCI) ? w_fibonacci : w_galois;
`ifdef PRPG_MISR_EN
      q_next = w_step ^ sig_in;
`else
      q_next = w_step;
`endif
   end

endmodule

// File: rtl/prpg_seq_engine.sv
// PRPG sequence engine: fetches instructions from a synchronous program ROM,
// configures and runs a W-bit LFSR for multi-cycle step counts, and moves
// patterns to and from a DEPTH-entry pattern memory.
// Optional feature macro: PRPG_MISR_EN (sig_in port and the MISR opcode).
module prpg_seq_engine
   import prpg_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH),
   parameter int PC_W  = 6,
   parameter int IW    = OP_W + W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [PC_W-1:0] prog_addr,
   input  logic [IW-1:0]   prog_instr,
   output logic [W-1:0]    q,
   output logic            busy,
   output logic            done,
   output logic            err,
   input  logic [AW-1:0]   dbg_addr,
   output logic [W-1:0]    dbg_data
`ifdef PRPG_MISR_EN
   ,
   input  logic [W-1:0]    sig_in
`endif
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e          r_state;
   logic [PC_W-1:0] r_pc;
   logic [W-1:0]    r_q;
   logic [W-1:0]    r_tap;
   logic            r_mode;
   logic [AW-1:0]   r_addr;
   logic [W-1:0]    r_run_cnt;
   logic            r_busy;
   logic            r_done;
   logic            r_err;
   logic [W-1:0]    r_dbg_data;
`ifdef PRPG_MISR_EN
   logic            r_misr;
`endif

   logic [W-1:0]    r_mem [DEPTH];

   // ---------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------
   logic [OP_W-1:0] w_op;
   logic [W-1:0]    w_opnd;
   logic            w_opnd_zero;
   logic            w_pc_last;
   logic            w_legal;
   logic            w_starts_run;
   logic [W-1:0]    w_seed;
   logic [W-1:0]    w_q_step;

   assign w_op        = prog_instr[IW-1:W];
   assign w_opnd      = prog_instr[W-1:0];
   assign w_opnd_zero = (w_opnd == '0);
   assign w_pc_last   = &r_pc;
   // A zero seed would lock the LFSR at zero, so it is replaced by 1.
   assign w_seed      = w_opnd_zero ? W'(1) : w_opnd;

   // Classify the fetched opcode: legal at all, and whether it enters RUN
   always_comb begin
      w_legal      = 1'b0;
      w_starts_run = 1'b0;
      case (w_op)
         OP_HALT, OP_CFG, OP_SEED, OP_IADDR,
         OP_ST, OP_LD, OP_AADD, OP_MODE: w_legal = 1'b1;
         OP_RUN: begin
            w_legal      = 1'b1;
            w_starts_run = !w_opnd_zero;
         end
`ifdef PRPG_MISR_EN
         OP_MISR: begin
            w_legal      = 1'b1;
            w_starts_run = !w_opnd_zero;
         end
`endif
         default: w_legal = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------
   // LFSR next state
   // ---------------------------------------------------------------------
`ifdef PRPG_MISR_EN
   logic [W-1:0] w_sig;
   // Plain RUN steps must not see the signature input.
   assign w_sig = r_misr ? sig_in : '0;
`endif

   prpg_lfsr_step #(.W(W)) u_step (
      .q      (r_q),
      .tap    (r_tap),
      .mode   (r_mode),
`ifdef PRPG_MISR_EN
      .sig_in (w_sig),
`endif
      .q_next (w_q_step)
   );

   // ---------------------------------------------------------------------
   // Sequencer FSM and architectural registers
   // ---------------------------------------------------------------------
   // Advance the FSM, execute the decoded instruction, step the LFSR in RUN
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_q       <= '0;
         r_tap     <= '0;
         r_mode    <= GALOIS;
         r_addr    <= '0;
         r_run_cnt <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
`ifdef PRPG_MISR_EN
         r_misr    <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_pc    <= '0;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_FETCH;
               end
            end

            // prog_addr already shows pc; the ROM word arrives next cycle.
            S_FETCH: r_state <= S_EXEC;

            S_EXEC: begin
               if (!w_legal || w_op == OP_HALT) begin
                  r_err   <= r_err | !w_legal;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  case (w_op)
                     OP_CFG:   r_tap  <= w_opnd;
                     OP_SEED:  r_q    <= w_seed;
                     OP_IADDR: r_addr <= w_opnd[AW-1:0];
                     OP_LD:    r_q    <= r_mem[r_addr];
                     OP_AADD:  r_addr <= r_addr + w_opnd[AW-1:0];
                     OP_MODE:  r_mode <= w_opnd[0];
                     OP_RUN:   r_run_cnt <= w_opnd;
`ifdef PRPG_MISR_EN
                     OP_MISR:  r_run_cnt <= w_opnd;
`endif
                     default: ;
                  endcase
`ifdef PRPG_MISR_EN
                  r_misr <= (w_op == OP_MISR);
`endif
                  if (w_starts_run) begin
                     r_state <= S_RUN;
                  end else if (w_pc_last) begin
                     // Falling off the end of the program is an error.
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_pc    <= r_pc + 1'b1;
                     r_state <= S_FETCH;
                  end
               end
            end

            S_RUN: begin
               r_q       <= w_q_step;
               r_run_cnt <= r_run_cnt - 1'b1;
               if (r_run_cnt == W'(1)) begin
                  if (w_pc_last) begin
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_pc    <= r_pc + 1'b1;
                     r_state <= S_FETCH;
                  end
               end
            end

            // done was raised on entry; this cycle just returns to IDLE.
            S_DONE: r_state <= S_IDLE;

            default: r_state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Pattern memory
   // ---------------------------------------------------------------------
   // Store q on ST; the array itself is never cleared
   always_ff @(posedge clk) begin
      // NOTE: the memory array has no reset so it maps onto RAM; its contents are undefined after reset.
      if (r_state == S_EXEC && w_op == OP_ST) begin
         r_mem[r_addr] <= r_q;
      end
   end

   // Registered debug read port; a same-cycle ST returns the old word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dbg_data <= '0;
      end else begin
         r_dbg_data <= r_mem[dbg_addr];
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign prog_addr = r_pc;
   assign q         = r_q;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign dbg_data  = r_dbg_data;

endmodule

// File: tb/tb_prpg_seq_engine.sv
// Self-checking bench for prpg_seq_engine (W=8, DEPTH=256, PC_W=6).
// Each program pushes its expected final {q, err} onto a scoreboard queue
// when started; the entry is popped and compared when done pulses.
// Build with PRPG_MISR_EN defined to exercise the MISR opcode.
module tb_prpg_seq_engine;
   import prpg_pkg::*;

   localparam int W     = 8;
   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int PC_W  = 6;
   localparam int IW    = OP_W + W;
   localparam int ROM_N = 1 << PC_W;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [PC_W-1:0] prog_addr;
   logic [IW-1:0]   prog_instr;
   logic [W-1:0]    q;
   logic            busy;
   logic            done;
   logic            err;
   logic [AW-1:0]   dbg_addr = '0;
   logic [W-1:0]    dbg_data;
`ifdef PRPG_MISR_EN
   logic [W-1:0]    sig_in = '0;
`endif

   prpg_seq_engine #(
      .W(W), .DEPTH(DEPTH), .AW(AW), .PC_W(PC_W), .IW(IW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .prog_addr  (prog_addr),
      .prog_instr (prog_instr),
      .q          (q),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
`ifdef PRPG_MISR_EN
      ,
      .sig_in     (sig_in)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous program ROM: data valid one cycle after the address
   logic [IW-1:0] rom [ROM_N];
   always @(posedge clk) prog_instr <= rom[prog_addr];

   typedef struct packed {
      logic [W-1:0] q;
      logic         err;
   } exp_t;
   exp_t sb_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [W-1:0] opnd);
      return {op, opnd};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < ROM_N; i++) rom[i] = ins(OP_HALT, 8'h00);
   endtask

   // Reference LFSR step written bit by bit from the mode definitions
   function automatic logic [W-1:0] model_step(input logic [W-1:0] s,
                                               input logic [W-1:0] tp,
                                               input logic md);
      logic [W-1:0] r;
      logic fb;
      if (md) begin
         r = {s[W-2:0], ^(s & tp)};
      end else begin
         fb   = s[W-1];
         r[0] = fb;
         for (int i = 1; i < W; i++) r[i] = s[i-1] ^ (tp[i] & fb);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] model_run(input logic [W-1:0] s,
                                              input logic [W-1:0] tp,
                                              input logic md, input int n);
      logic [W-1:0] r;
      r = s;
      for (int i = 0; i < n; i++) r = model_step(r, tp, md);
      return r;
   endfunction

   // Start the program in rom, wait (bounded) for done, compare scoreboard
   task automatic run_prog(input string tag, input logic [W-1:0] exp_q, input logic exp_err);
      exp_t e;
      int   cyc;
      sb_q.push_back('{q: exp_q, err: exp_err});
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({tag, "_busy_on"}, busy, 1);
      check({tag, "_err_clr"}, err, 0);
      cyc = 0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      e = sb_q.pop_front();
      if (!done) begin
         check({tag, "_timeout"}, done, 1);
      end else begin
         check({tag, "_q"}, q, e.q);
         check({tag, "_err"}, err, e.err);
         check({tag, "_busy_off"}, busy, 0);
         @(negedge clk);
         check({tag, "_done_pulse"}, done, 0);
      end
   endtask

   initial begin
      int done_seen;

      clear_rom();
      repeat (2) @(negedge clk);
      check("rst_q", q, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_dbg", dbg_data, 0);
      check("rst_pc", prog_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Galois single step from 0x80 with tap 0x8E
      clear_rom();
      rom[0] = ins(OP_CFG, 8'h8E);
      rom[1] = ins(OP_SEED, 8'h80);
      rom[2] = ins(OP_RUN, 8'h01);
      run_prog("p_basic", 8'h8F, 1'b0);

      // Primitive polynomial x^8+x^4+x^3+x^2+1 returns to the seed after 255 steps
      clear_rom();
      rom[0] = ins(OP_CFG, 8'h1D);
      rom[1] = ins(OP_SEED, 8'h01);
      rom[2] = ins(OP_RUN, 8'hFF);
      run_prog("p_period", 8'h01, 1'b0);

      // Long run with tap 0x8E, then one more step
      clear_rom();
      rom[0] = ins(OP_CFG, 8'h8E);
      rom[1] = ins(OP_SEED, 8'h01);
      rom[2] = ins(OP_RUN, 8'hFF);
      rom[3] = ins(OP_RUN, 8'h01);
      run_prog("p_run256", model_run(8'h01, 8'h8E, 1'b0, 256), 1'b0);

      // Fibonacci mode
      clear_rom();
      rom[0] = ins(OP_MODE, 8'h01);
      rom[1] = ins(OP_CFG, 8'h8E);
      rom[2] = ins(OP_SEED, 8'h01);
      rom[3] = ins(OP_RUN, 8'h01);
      run_prog("p_fib1", 8'h02, 1'b0);

      clear_rom();
      rom[0] = ins(OP_MODE, 8'h01);
      rom[1] = ins(OP_CFG, 8'h8E);
      rom[2] = ins(OP_SEED, 8'h04);
      rom[3] = ins(OP_RUN, 8'h01);
      run_prog("p_fib_par", 8'h09, 1'b0);

      // RUN 0 takes no step; then 17 Fibonacci steps
      clear_rom();
      rom[0] = ins(OP_MODE, 8'h01);
      rom[1] = ins(OP_CFG, 8'h8E);
      rom[2] = ins(OP_SEED, 8'h5B);
      rom[3] = ins(OP_RUN, 8'h00);
      rom[4] = ins(OP_RUN, 8'h11);
      run_prog("p_fib17", model_run(8'h5B, 8'h8E, 1'b1, 17), 1'b0);

      // Pattern memory: store at 0xFF, wrap to 0x01, store, zero seed becomes 1
      clear_rom();
      rom[0] = ins(OP_MODE, 8'h00);
      rom[1] = ins(OP_SEED, 8'h5A);
      rom[2] = ins(OP_IADDR, 8'hFF);
      rom[3] = ins(OP_ST, 8'h00);
      rom[4] = ins(OP_AADD, 8'h02);
      rom[5] = ins(OP_SEED, 8'h3C);
      rom[6] = ins(OP_ST, 8'h00);
      rom[7] = ins(OP_SEED, 8'h00);
      run_prog("p_mem", 8'h01, 1'b0);
      dbg_addr = 8'hFF;
      @(negedge clk);
      check("dbg_ff", dbg_data, 8'h5A);
      dbg_addr = 8'h01;
      @(negedge clk);
      check("dbg_01", dbg_data, 8'h3C);

      // LD after the same wrapping address arithmetic
      clear_rom();
      rom[0] = ins(OP_IADDR, 8'hFF);
      rom[1] = ins(OP_AADD, 8'h02);
      rom[2] = ins(OP_SEED, 8'h77);
      rom[3] = ins(OP_LD, 8'h00);
      run_prog("p_ld", 8'h3C, 1'b0);

      // Illegal opcode, then a clean program clears err
      clear_rom();
      rom[0] = ins(OP_SEED, 8'h21);
      rom[1] = ins(4'hF, 8'h00);
      run_prog("p_illegal", 8'h21, 1'b1);

      clear_rom();
      rom[0] = ins(OP_CFG, 8'h8E);
      rom[1] = ins(OP_SEED, 8'h80);
      rom[2] = ins(OP_RUN, 8'h01);
      run_prog("p_after_err", 8'h8F, 1'b0);

`ifdef PRPG_MISR_EN
      clear_rom();
      rom[0] = ins(OP_MODE, 8'h00);
      rom[1] = ins(OP_SEED, 8'h01);
      rom[2] = ins(OP_MISR, 8'h01);
      sig_in = 8'hFF;
      run_prog("p_misr", 8'hFD, 1'b0);
      sig_in = 8'h00;
`else
      clear_rom();
      rom[0] = ins(OP_SEED, 8'h11);
      rom[1] = ins(4'h9, 8'h01);
      run_prog("p_op9", 8'h11, 1'b1);
`endif

      // Program counter overflow: last slot not HALT, then last slot HALT
      for (int i = 0; i < ROM_N; i++) rom[i] = ins(OP_SEED, 8'h05);
      run_prog("p_pc_ovf", 8'h05, 1'b1);
      rom[ROM_N-1] = ins(OP_HALT, 8'h00);
      run_prog("p_pc_last_halt", 8'h05, 1'b0);

      // Reset in the middle of a long RUN
      clear_rom();
      rom[0] = ins(OP_CFG, 8'h1D);
      rom[1] = ins(OP_SEED, 8'h01);
      rom[2] = ins(OP_RUN, 8'hC8);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (20) @(negedge clk);
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_q", q, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_dbg", dbg_data, 0);
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("mid_rst_no_done", done_seen, 0);
      check("mid_rst_idle", busy, 0);
      check("sb_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
